// File: rtl/demosaic_bilinear.sv
// Streaming bilinear Bayer demosaic: two line memories feed a 3x3 window, mirrored at the
// frame edges, followed by a two-step interpolation pipeline and an end-of-frame drain.
module demosaic_bilinear #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIDTH  = 1920,
    parameter int unsigned HEIGHT = 1080,
    parameter int unsigned BAYER  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              iReady,
    output logic [DATA_W-1:0] oR,
    output logic [DATA_W-1:0] oG,
    output logic [DATA_W-1:0] oB,
    output logic [15:0]       xCnt,
    output logic [15:0]       yCnt,
    output logic              oValid,
    output logic              oDone
);

    localparam int unsigned SUM_W       = DATA_W + 2;
    localparam int unsigned AW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [15:0] X_LAST      = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST      = 16'(HEIGHT - 1);
    localparam logic [15:0] DRAIN_FEEDS = 16'(WIDTH + 1);
    localparam logic [15:0] DRAIN_LAST  = 16'(WIDTH + 2);
    localparam logic [1:0]  PHASE       = 2'(BAYER);

    typedef enum logic [1:0] {StFill, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [15:0]        dcnt_q, dcnt_d;
    logic [15:0]        col_q, row_q;
    logic               run_st, accept, drain, adv, feed, in_last;
    logic [DATA_W-1:0]  pix;

    assign run_st  = (state_q == StFill) || (state_q == StRun);
    assign iReady  = reset & run_st;
    assign accept  = iValid & run_st;
    assign drain   = (state_q == StDrain);
    assign adv     = accept | drain;
    // Drain feeds WIDTH+1 dummy columns; the rows they stand for are mirrored away below.
    assign feed    = accept | (drain & (dcnt_q < DRAIN_FEEDS));
    assign in_last = (col_q == X_LAST) && (row_q == Y_LAST);
    assign pix     = accept ? iData : '0;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            StFill: if (accept && row_q == 16'd1 && col_q == 16'd0) state_d = StRun;
            StRun: begin
                if (accept && in_last) begin
                    state_d = StDrain;
                    dcnt_d  = '0;
                end
            end
            StDrain: begin
                dcnt_d = dcnt_q + 16'd1;
                if (dcnt_q == DRAIN_LAST) state_d = StDone;
            end
            StDone:  state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFill;
            dcnt_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (state_q == StDone) begin
                col_q <= '0;
                row_q <= '0;
            end else if (feed) begin
                if (col_q == X_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 16'd1;
                end else begin
                    col_q <= col_q + 16'd1;
                end
            end
        end
    end

    // Each entry holds {row-2, row-1} for its column.
    logic [2*DATA_W-1:0] line_mem [WIDTH];
    logic [2*DATA_W-1:0] line_rd;
    logic [AW-1:0]       col_idx;

    assign col_idx = col_q[AW-1:0];
    assign line_rd = line_mem[col_idx];

    always_ff @(posedge clk) begin
        if (feed) line_mem[col_idx] <= {line_rd[DATA_W-1:0], pix};
    end

    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] new_col [3];
    logic [15:0]       wx_q, wy_q, wx_d, wy_d;
    logic              wv_q, wv_d;

    assign new_col[0] = line_rd[2*DATA_W-1:DATA_W];
    assign new_col[1] = line_rd[DATA_W-1:0];
    assign new_col[2] = pix;

    // Window centre lags the fed column by one row and one column.
    assign wv_d = feed && ((row_q >= 16'd2) || (row_q == 16'd1 && col_q != 16'd0));
    assign wx_d = (col_q == 16'd0) ? X_LAST : col_q - 16'd1;
    assign wy_d = (col_q == 16'd0) ? row_q - 16'd2 : row_q - 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
            end
            wv_q <= 1'b0;
            wx_q <= '0;
            wy_q <= '0;
        end else if (adv) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= new_col[r];
            end
            wv_q <= wv_d;
            wx_q <= wx_d;
            wy_q <= wy_d;
        end
    end

    logic [DATA_W-1:0] rowv [3][3];
    logic [DATA_W-1:0] m    [3][3];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            rowv[r][0] = (wx_q == 16'd0)  ? win_q[r][2] : win_q[r][0];
            rowv[r][1] = win_q[r][1];
            rowv[r][2] = (wx_q == X_LAST) ? win_q[r][0] : win_q[r][2];
        end
        for (int c = 0; c < 3; c++) begin
            m[0][c] = (wy_q == 16'd0)  ? rowv[2][c] : rowv[0][c];
            m[1][c] = rowv[1][c];
            m[2][c] = (wy_q == Y_LAST) ? rowv[0][c] : rowv[2][c];
        end
    end

    logic [SUM_W-1:0] cross_sum, diag_sum, horz_sum, vert_sum;

    assign vert_sum  = SUM_W'(m[0][1]) + SUM_W'(m[2][1]);
    assign horz_sum  = SUM_W'(m[1][0]) + SUM_W'(m[1][2]);
    assign cross_sum = vert_sum + horz_sum;
    assign diag_sum  = SUM_W'(m[0][0]) + SUM_W'(m[0][2]) + SUM_W'(m[2][0]) + SUM_W'(m[2][2]);

    logic              s1_v_q;
    logic [15:0]       s1_x_q, s1_y_q;
    logic [1:0]        s1_site_q;
    logic [DATA_W-1:0] s1_c_q, s1_cr_q, s1_dg_q, s1_hz_q, s1_vt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v_q    <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_site_q <= '0;
            s1_c_q    <= '0;
            s1_cr_q   <= '0;
            s1_dg_q   <= '0;
            s1_hz_q   <= '0;
            s1_vt_q   <= '0;
        end else if (adv) begin
            s1_v_q    <= wv_q;
            s1_x_q    <= wx_q;
            s1_y_q    <= wy_q;
            s1_site_q <= {wy_q[0] ^ PHASE[1], wx_q[0] ^ PHASE[0]};
            s1_c_q    <= m[1][1];
            s1_cr_q   <= DATA_W'(cross_sum >> 2);
            s1_dg_q   <= DATA_W'(diag_sum >> 2);
            s1_hz_q   <= DATA_W'(horz_sum >> 1);
            s1_vt_q   <= DATA_W'(vert_sum >> 1);
        end
    end

    logic [DATA_W-1:0] r_d, g_d, b_d;

    // Site code {row phase, column phase}: 00 R, 01 G on R row, 10 G on B row, 11 B.
    always_comb begin
        r_d = s1_c_q;
        g_d = s1_c_q;
        b_d = s1_c_q;
        unique case (s1_site_q)
            2'b00: begin g_d = s1_cr_q; b_d = s1_dg_q; end
            2'b01: begin r_d = s1_hz_q; b_d = s1_vt_q; end
            2'b10: begin b_d = s1_hz_q; r_d = s1_vt_q; end
            2'b11: begin g_d = s1_cr_q; r_d = s1_dg_q; end
            default: ;
        endcase
    end

    logic [DATA_W-1:0] out_r_q, out_g_q, out_b_q;
    logic [15:0]       out_x_q, out_y_q;
    logic              out_v_q, out_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r_q    <= '0;
            out_g_q    <= '0;
            out_b_q    <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_v_q    <= 1'b0;
            out_done_q <= 1'b0;
        end else begin
            out_v_q    <= adv & s1_v_q;
            out_done_q <= adv & s1_v_q & (s1_x_q == X_LAST) & (s1_y_q == Y_LAST);
            if (adv && s1_v_q) begin
                out_r_q <= r_d;
                out_g_q <= g_d;
                out_b_q <= b_d;
                out_x_q <= s1_x_q;
                out_y_q <= s1_y_q;
            end
        end
    end

    assign oR     = out_r_q;
    assign oG     = out_g_q;
    assign oB     = out_b_q;
    assign xCnt   = out_x_q;
    assign yCnt   = out_y_q;
    assign oValid = out_v_q;
    assign oDone  = out_done_q;

endmodule

// File: tb/tb_demosaic_bilinear.sv
// Directed bench for demosaic_bilinear on a 4x4 frame, one instance per CFA phase.
module tb_demosaic_bilinear;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int N    = W * H;
    localparam int DW   = 8;
    localparam int NDUT = 4;
    localparam int CAP  = 256;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic [DW-1:0] iData  = '0;
    logic          iValid = 1'b0;

    logic          i_ready [NDUT];
    logic [DW-1:0] o_r     [NDUT];
    logic [DW-1:0] o_g     [NDUT];
    logic [DW-1:0] o_b     [NDUT];
    logic [15:0]   x_cnt   [NDUT];
    logic [15:0]   y_cnt   [NDUT];
    logic          o_valid [NDUT];
    logic          o_done  [NDUT];

    int img [N];
    int checks = 0;
    int errors = 0;

    int cap_n [NDUT];
    int cap_r [NDUT][CAP];
    int cap_g [NDUT][CAP];
    int cap_b [NDUT][CAP];
    int cap_x [NDUT][CAP];
    int cap_y [NDUT][CAP];
    int cap_d [NDUT][CAP];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        demosaic_bilinear #(
            .DATA_W(DW),
            .WIDTH (W),
            .HEIGHT(H),
            .BAYER (g)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .iData (iData),
            .iValid(iValid),
            .iReady(i_ready[g]),
            .oR    (o_r[g]),
            .oG    (o_g[g]),
            .oB    (o_b[g]),
            .xCnt  (x_cnt[g]),
            .yCnt  (y_cnt[g]),
            .oValid(o_valid[g]),
            .oDone (o_done[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (o_valid[k]) begin
                if (cap_n[k] < CAP) begin
                    cap_r[k][cap_n[k]] = int'(o_r[k]);
                    cap_g[k][cap_n[k]] = int'(o_g[k]);
                    cap_b[k][cap_n[k]] = int'(o_b[k]);
                    cap_x[k][cap_n[k]] = int'(x_cnt[k]);
                    cap_y[k][cap_n[k]] = int'(y_cnt[k]);
                    cap_d[k][cap_n[k]] = int'(o_done[k]);
                end
                cap_n[k] = cap_n[k] + 1;
            end
        end
    end

    // 0 = R, 1 = G, 2 = B
    function automatic int colour_at(input int bayer, input int x, input int y);
        int px = (x & 1) ^ (bayer & 1);
        int py = (y & 1) ^ ((bayer >> 1) & 1);
        if (py == 0) return (px == 0) ? 0 : 1;
        return (px == 0) ? 1 : 2;
    endfunction

    function automatic int mir(input int v, input int n);
        if (v < 0) return -v;
        if (v >= n) return 2 * n - 2 - v;
        return v;
    endfunction

    // Average of the same-colour pixels among the 8 mirrored neighbours.
    function automatic int model(input int bayer, input int x, input int y, input int ch);
        int sum = 0;
        int n = 0;
        if (colour_at(bayer, x, y) == ch) return img[y * W + x];
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int xx = mir(x + dx, W);
                int yy = mir(y + dy, H);
                if ((dx != 0 || dy != 0) && colour_at(bayer, xx, yy) == ch) begin
                    sum += img[yy * W + xx];
                    n++;
                end
            end
        end
        return sum / n;
    endfunction

    task automatic set_flat(input int v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) img[i] = 16 * (i / W) + 4 * (i % W);
    endtask

    task automatic send_frame(input int gap, output int waits);
        int t;
        waits = 0;
        for (int i = 0; i < N; i++) begin
            iValid = 1'b1;
            iData  = DW'(img[i]);
            t = 0;
            while (i_ready[0] !== 1'b1 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (i == 0) waits = t;
            if (t >= 100) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: pixel %0d iReady=%0b required 1", i, i_ready[0]);
            end
            @(posedge clk); #1;
            iValid = 1'b0;
            for (int j = 0; j < gap; j++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_frame(input int target);
        int t = 0;
        while (cap_n[0] < target && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (cap_n[0] < target) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: outputs %0d required %0d", cap_n[0], target);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if ({i_ready[k], o_valid[k], o_done[k], o_r[k], o_g[k], o_b[k], x_cnt[k],
                 y_cnt[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: rdy=%0b v=%0b d=%0b rgb=%0d/%0d/%0d xy=%0d/%0d required all 0",
                         k, i_ready[k], o_valid[k], o_done[k], o_r[k], o_g[k], o_b[k],
                         x_cnt[k], y_cnt[k]);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (i_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: iReady=%0b required 1", i_ready[0]);
        end
    endtask

    task automatic test_flat();
        int base = cap_n[0];
        int w;
        set_flat(100);
        send_frame(0, w);
        wait_frame(base + N);
        checks++;
        if (cap_n[0] - base !== N) begin
            errors++;
            $display("FAIL flat_count: pulses %0d required %0d", cap_n[0] - base, N);
        end
        for (int i = 0; i < N; i++) begin
            int idx = base + i;
            checks++;
            if (cap_r[0][idx] !== 100 || cap_g[0][idx] !== 100 || cap_b[0][idx] !== 100) begin
                errors++;
                $display("FAIL flat_rgb px%0d: got %0d/%0d/%0d required 100/100/100", i,
                         cap_r[0][idx], cap_g[0][idx], cap_b[0][idx]);
            end
            checks++;
            if (cap_x[0][idx] !== i % W || cap_y[0][idx] !== i / W ||
                cap_d[0][idx] !== int'(i == N - 1)) begin
                errors++;
                $display("FAIL flat_coord px%0d: got x=%0d y=%0d done=%0d required %0d/%0d/%0d",
                         i, cap_x[0][idx], cap_y[0][idx], cap_d[0][idx], i % W, i / W,
                         int'(i == N - 1));
            end
        end
    endtask

    task automatic test_ramp();
        int base = cap_n[0];
        int w;
        int want [NDUT][3];
        set_ramp();
        send_frame(0, w);
        wait_frame(base + N);
        // Hand-computed pixel (0,0) for each phase: {R, G, B}
        want[0] = '{0, 10, 20};
        want[1] = '{4, 0, 16};
        want[2] = '{16, 0, 4};
        want[3] = '{20, 10, 0};
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (cap_r[k][base] !== want[k][0] || cap_g[k][base] !== want[k][1] ||
                cap_b[k][base] !== want[k][2]) begin
                errors++;
                $display("FAIL ramp_origin dut%0d: got %0d/%0d/%0d required %0d/%0d/%0d", k,
                         cap_r[k][base], cap_g[k][base], cap_b[k][base], want[k][0],
                         want[k][1], want[k][2]);
            end
        end
        checks++;
        if (cap_r[0][base + 5] !== 20 || cap_g[0][base + 5] !== 20 ||
            cap_b[0][base + 5] !== 20) begin
            errors++;
            $display("FAIL ramp_1_1: got %0d/%0d/%0d required 20/20/20", cap_r[0][base + 5],
                     cap_g[0][base + 5], cap_b[0][base + 5]);
        end
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < N; i++) begin
                int idx = base + i;
                int er = model(k, i % W, i / W, 0);
                int eg = model(k, i % W, i / W, 1);
                int eb = model(k, i % W, i / W, 2);
                checks++;
                if (cap_r[k][idx] !== er || cap_g[k][idx] !== eg || cap_b[k][idx] !== eb ||
                    cap_x[k][idx] !== i % W || cap_y[k][idx] !== i / W) begin
                    errors++;
                    $display("FAIL ramp_model dut%0d px%0d: got %0d/%0d/%0d @%0d,%0d required %0d/%0d/%0d @%0d,%0d",
                             k, i, cap_r[k][idx], cap_g[k][idx], cap_b[k][idx], cap_x[k][idx],
                             cap_y[k][idx], er, eg, eb, i % W, i / W);
                end
            end
        end
    endtask

    task automatic test_sparse_valid();
        int base = cap_n[0];
        int w;
        set_ramp();
        send_frame(1, w);
        wait_frame(base + N);
        checks++;
        if (cap_n[0] - base !== N) begin
            errors++;
            $display("FAIL sparse_count: pulses %0d required %0d", cap_n[0] - base, N);
        end
        for (int i = 0; i < N; i++) begin
            int idx = base + i;
            int er = model(0, i % W, i / W, 0);
            int eg = model(0, i % W, i / W, 1);
            int eb = model(0, i % W, i / W, 2);
            checks++;
            if (cap_r[0][idx] !== er || cap_g[0][idx] !== eg || cap_b[0][idx] !== eb ||
                cap_x[0][idx] !== i % W || cap_y[0][idx] !== i / W ||
                cap_d[0][idx] !== int'(i == N - 1)) begin
                errors++;
                $display("FAIL sparse_px%0d: got %0d/%0d/%0d @%0d,%0d d%0d required %0d/%0d/%0d @%0d,%0d",
                         i, cap_r[0][idx], cap_g[0][idx], cap_b[0][idx], cap_x[0][idx],
                         cap_y[0][idx], cap_d[0][idx], er, eg, eb, i % W, i / W);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base = cap_n[0];
        int w1;
        int w2;
        set_ramp();
        send_frame(0, w1);
        send_frame(0, w2);
        wait_frame(base + 2 * N);
        checks++;
        if (w1 !== 0 || w2 !== W + 4) begin
            errors++;
            $display("FAIL b2b_ready_gap: first=%0d second=%0d required 0 and %0d", w1, w2,
                     W + 4);
        end
        checks++;
        if (cap_n[0] - base !== 2 * N) begin
            errors++;
            $display("FAIL b2b_count: pulses %0d required %0d", cap_n[0] - base, 2 * N);
        end
        for (int i = 0; i < 2 * N; i++) begin
            int idx = base + i;
            int p = i % N;
            int er = model(0, p % W, p / W, 0);
            int eg = model(0, p % W, p / W, 1);
            int eb = model(0, p % W, p / W, 2);
            checks++;
            if (cap_r[0][idx] !== er || cap_g[0][idx] !== eg || cap_b[0][idx] !== eb ||
                cap_x[0][idx] !== p % W || cap_y[0][idx] !== p / W ||
                cap_d[0][idx] !== int'(p == N - 1)) begin
                errors++;
                $display("FAIL b2b_out%0d: got %0d/%0d/%0d @%0d,%0d d%0d required %0d/%0d/%0d @%0d,%0d",
                         i, cap_r[0][idx], cap_g[0][idx], cap_b[0][idx], cap_x[0][idx],
                         cap_y[0][idx], cap_d[0][idx], er, eg, eb, p % W, p / W);
            end
        end
    endtask

    task automatic test_mid_reset();
        int base;
        int w;
        set_ramp();
        for (int i = 0; i < 7; i++) begin
            iValid = 1'b1;
            iData  = DW'(img[i]);
            @(posedge clk); #1;
        end
        iData = DW'(img[7]);
        reset = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if ({i_ready[k], o_valid[k], o_done[k], o_r[k], o_g[k], o_b[k], x_cnt[k],
                 y_cnt[k]} !== '0) begin
                errors++;
                $display("FAIL midreset_outputs dut%0d: rdy=%0b rgb=%0d/%0d/%0d xy=%0d/%0d required all 0",
                         k, i_ready[k], o_r[k], o_g[k], o_b[k], x_cnt[k], y_cnt[k]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (i_ready[0] !== 1'b0 || o_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hold: iReady=%0b oValid=%0b required 0/0", i_ready[0],
                     o_valid[0]);
        end
        reset  = 1'b1;
        iValid = 1'b0;
        @(posedge clk); #1;
        base = cap_n[0];
        send_frame(0, w);
        wait_frame(base + N);
        checks++;
        if (cap_n[0] - base !== N) begin
            errors++;
            $display("FAIL midreset_count: pulses %0d required %0d", cap_n[0] - base, N);
        end
        for (int i = 0; i < N; i++) begin
            int idx = base + i;
            int er = model(0, i % W, i / W, 0);
            int eg = model(0, i % W, i / W, 1);
            int eb = model(0, i % W, i / W, 2);
            checks++;
            if (cap_r[0][idx] !== er || cap_g[0][idx] !== eg || cap_b[0][idx] !== eb ||
                cap_x[0][idx] !== i % W || cap_y[0][idx] !== i / W ||
                cap_d[0][idx] !== int'(i == N - 1)) begin
                errors++;
                $display("FAIL midreset_px%0d: got %0d/%0d/%0d @%0d,%0d d%0d required %0d/%0d/%0d @%0d,%0d",
                         i, cap_r[0][idx], cap_g[0][idx], cap_b[0][idx], cap_x[0][idx],
                         cap_y[0][idx], cap_d[0][idx], er, eg, eb, i % W, i / W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp();
        test_sparse_valid();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demosaic_bilinear.md
DEMOSAIC_BILINEAR -- requirements
Module: demosaic_bilinear

Interface
REQ-001 Parameter DATA_W, default 8: pixel bit width (range 8..14).
REQ-002 Parameter WIDTH, default 1920: active pixels per line (even, >=4).
REQ-003 Parameter HEIGHT, default 1080: active lines per frame (even, >=4).
REQ-004 Parameter BAYER, default 0: CFA phase of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-007 iData  input  DATA_W  raw Bayer pixel, raster order, frame starts at (0,0).
REQ-008 iValid  input  1  iData valid this cycle.
REQ-009 iReady  output  1  block accepts iData this cycle; accept = iValid & iReady.
REQ-010 oR, oG, oB  output  DATA_W each  interpolated RGB of current output pixel.
REQ-011 xCnt, yCnt  output  16 each  coordinates of current output pixel.
REQ-012 oValid  output  1  one-cycle pulse per output pixel.
REQ-013 oDone  output  1  high together with oValid of pixel (WIDTH-1,HEIGHT-1) only.

Function
REQ-014 Block SHALL hold two full lines of history in internal inferred memory (no vendor megafunction) plus a 3x3 register window.
REQ-015 Window SHALL advance on adv = accept | drain-cycle; no state other than the counters and drain FSM changes on non-adv cycles.
REQ-016 Output pixel n = y*WIDTH+x SHALL have its window complete on the adv carrying input index n+WIDTH+1 (or its drain equivalent).
REQ-017 Out-of-image neighbours SHALL be mirrored (x=-1 -> 1, x=WIDTH -> WIDTH-2, same for y) so CFA phase is preserved.
REQ-018 Centre colour SHALL pass through unchanged.
REQ-019 G at R/B sites SHALL be (N+S+E+W)>>2; R/B at the opposite chroma site SHALL be (sum of 4 diagonals)>>2.
REQ-020 At G sites, the chroma on the same row SHALL be (E+W)>>1, the chroma on the same column (N+S)>>1.
REQ-021 Sums SHALL use DATA_W+2 bits; results truncate (no rounding), never overflow.
REQ-022 Pipeline from window-complete adv to output register SHALL be exactly 2 adv steps; oValid asserts the cycle after the adv that loads the output register and is low on every other cycle.
REQ-023 oR/oG/oB/xCnt/yCnt SHALL hold their last value while oValid is low.
REQ-024 Drain FSM states: FILL (iReady=1, no output until WIDTH+1 inputs accepted), RUN (iReady=1), DRAIN (iReady=0, one adv per cycle using mirrored rows), DONE-hold (1 cycle, iReady=0).
REQ-025 FILL->RUN on accept of input index WIDTH; RUN->DRAIN the cycle after accepting input index WIDTH*HEIGHT-1.
REQ-026 DRAIN SHALL last WIDTH+3 cycles (WIDTH+1 window steps + 2 pipeline steps), then DONE-hold, then FILL for next frame with all counters zeroed.
REQ-027 iValid during DRAIN/DONE-hold SHALL be ignored (not accepted, not lost from source since iReady=0).
REQ-028 Exactly WIDTH*HEIGHT oValid pulses per frame, in raster order; xCnt wraps at WIDTH-1 to 0 and increments yCnt.

Reset
REQ-029 While reset is low: iReady=0, oValid=0, oDone=0, oR/oG/oB=0, xCnt=yCnt=0, FSM=FILL, window and counters cleared.
REQ-030 First cycle after reset release iReady SHALL be 1; reset asserted mid-frame SHALL abandon the frame, next accepted pixel is (0,0).
REQ-031 Line memory contents need not be cleared; no output may depend on unwritten memory.

Verification
REQ-032 W=H=4, DATA_W=8, BAYER=0, all pixels 100 -> 16 oValid pulses, every oR=oG=oB=100, oDone on 16th only.
REQ-033 W=H=4, BAYER=0, pixel=16*y+4*x -> (1,1): R=G=B=20; (0,0): R=0, G=10, B=20.
REQ-034 Same ramp with iValid high every other cycle -> identical output sequence and values to REQ-033.
REQ-035 After final accept -> iReady low exactly WIDTH+4 cycles; second frame accepted immediately after, outputs identical to first.
REQ-036 Reset pulsed low at input index 7 of frame -> all outputs 0 during reset; restart frame produces full correct 16-pixel result.
REQ-037 BAYER=1..3 with REQ-033 ramp -> centre pass-through colour at (0,0) matches phase (G, G, B), interpolated values match reference model.
